// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder with a valid/ready handshake on both sides.
// {cout,S} = X + Y + cin, ovf = carry into MSB ^ carry out of MSB.
// STAGES register slices are spread evenly over the prefix levels plus the sum XOR.
// Optional macro PREFIX_ADDER_SUB_EN adds a 'sub' input (X + ~Y + 1, cin ignored).
module pipelined_prefix_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cin,
`ifdef PREFIX_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned LVLS  = $clog2(WIDTH);
    localparam int unsigned STEPS = LVLS + 1;

    // Slice whose register closes after the given step, or STAGES if none does.
    function automatic int unsigned bnd_slice(input int unsigned step);
        int unsigned k_hit;
        k_hit = STAGES;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if ((((k + 1) * STEPS) / STAGES) - 1 == step) begin
                k_hit = k;
            end
        end
        return k_hit;
    endfunction

    // ------------------------------------------------------------------
    // Handshake: one valid bit per slice, bubbles collapse.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_ld;
    logic              r_run;
    logic              w_fire;

    // Advance chain from the output slice back to slice 0.
    always_comb begin
        logic a;
        w_adv = '0;
        a = ~r_vld[STAGES-1] | out_ready;
        w_adv[STAGES-1] = a;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            a = ~r_vld[k] | a;
            w_adv[k] = a;
        end
    end

    assign in_ready = r_run & w_adv[0];
    assign w_fire   = in_valid & in_ready;

    // Valid bit offered to each slice by its upstream neighbour.
    always_comb begin
        w_vin    = '0;
        w_vin[0] = w_fire;
        for (int k = 1; k < int'(STAGES); k++) begin
            w_vin[k] = r_vld[k-1];
        end
    end

    assign w_ld      = w_adv & w_vin;
    assign out_valid = r_vld[STAGES-1];

    // Slice valid bits and the post-reset run flag that gates in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_vld <= '0;
        end else begin
            r_run <= 1'b1;
            r_vld <= (r_vld & ~w_adv) | (w_vin & w_adv);
        end
    end

    // ------------------------------------------------------------------
    // Operand conditioning: cin folded into bit-0 generate.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_yop;
    logic             w_cop;
    logic [WIDTH-1:0] w_gen;
    logic [WIDTH-1:0] w_prp;

`ifdef PREFIX_ADDER_SUB_EN
    assign w_yop = sub ? ~Y : Y;
    assign w_cop = sub | cin;
`else
    assign w_yop = Y;
    assign w_cop = cin;
`endif

    // Bitwise generate/propagate, carry-in merged into position 0.
    always_comb begin
        w_prp    = X ^ w_yop;
        w_gen    = X & w_yop;
        w_gen[0] = w_gen[0] | (w_prp[0] & w_cop);
    end

    // Inputs to each prefix level; index LVLS feeds the sum step.
    logic [WIDTH-1:0] w_g  [0:LVLS];
    logic [WIDTH-1:0] w_hp [0:LVLS];
    logic [WIDTH-1:0] w_p  [0:LVLS-1];
    logic             w_c  [0:LVLS];

    assign w_g[0]  = w_gen;
    assign w_hp[0] = w_prp;
    assign w_p[0]  = w_prp;
    assign w_c[0]  = w_cop;

    // ------------------------------------------------------------------
    // Kogge-Stone levels, optionally closed by a slice register.
    // ------------------------------------------------------------------
    for (genvar s = 0; s < int'(LVLS); s++) begin : g_lvl
        localparam int unsigned DIST  = 32'(1) << s;
        localparam int unsigned SLICE = bnd_slice(s);
        localparam bit          LAST  = (s == int'(LVLS) - 1);

        logic [WIDTH-1:0] w_go;

        // Group generate combine at distance DIST.
        always_comb begin
            w_go = w_g[s];
            for (int i = DIST; i < int'(WIDTH); i++) begin
                w_go[i] = w_g[s][i] | (w_p[s][i] & w_g[s][i-DIST]);
            end
        end

        if (SLICE < STAGES) begin : g_reg
            logic [WIDTH-1:0] r_g;
            logic [WIDTH-1:0] r_hp;
            logic             r_c;

            // Slice register for generate, half-sum and carry-in.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_g  <= '0;
                    r_hp <= '0;
                    r_c  <= 1'b0;
                end else if (w_ld[SLICE]) begin
                    r_g  <= w_go;
                    r_hp <= w_hp[s];
                    r_c  <= w_c[s];
                end
            end

            assign w_g[s+1]  = r_g;
            assign w_hp[s+1] = r_hp;
            assign w_c[s+1]  = r_c;
        end else begin : g_wire
            assign w_g[s+1]  = w_go;
            assign w_hp[s+1] = w_hp[s];
            assign w_c[s+1]  = w_c[s];
        end

        // The last level's group propagate has no consumer.
        if (!LAST) begin : g_prp
            logic [WIDTH-1:0] w_po;

            // Group propagate combine at distance DIST.
            always_comb begin
                w_po = w_p[s];
                for (int i = DIST; i < int'(WIDTH); i++) begin
                    w_po[i] = w_p[s][i] & w_p[s][i-DIST];
                end
            end

            if (SLICE < STAGES) begin : g_reg
                logic [WIDTH-1:0] r_p;

                // Slice register for group propagate.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_p <= '0;
                    end else if (w_ld[SLICE]) begin
                        r_p <= w_po;
                    end
                end

                assign w_p[s+1] = r_p;
            end else begin : g_wire
                assign w_p[s+1] = w_po;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sum step and output slice.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_cy;
    logic [WIDTH-1:0] w_sum;
    logic             w_co;
    logic             w_ov;

    // Carries into each bit, sum XOR, carry out and signed overflow.
    always_comb begin
        w_cy  = {w_g[LVLS][WIDTH-2:0], w_c[LVLS]};
        w_sum = w_hp[LVLS] ^ w_cy;
        w_co  = w_g[LVLS][WIDTH-1];
        w_ov  = w_cy[WIDTH-1] ^ w_co;
    end

    // Output slice register; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (w_ld[STAGES-1]) begin
            S    <= w_sum;
            cout <= w_co;
            ovf  <= w_ov;
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for pipelined_prefix_adder (WIDTH=16, STAGES=2).
module tb_pipelined_prefix_adder;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         cout;
    logic         ovf;
`ifdef PREFIX_ADDER_SUB_EN
    logic         sub;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [17:0] sb [$];
    bit          rnd_or = 1'b0;
    vec_t        dv [8];
    int          w;
    int          w0;
    int          w1;
    int          wsum;
    logic [15:0] rx;
    logic [15:0] ry;
    logic        rc;

    pipelined_prefix_adder #(.WIDTH(16), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .cin       (cin),
`ifdef PREFIX_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] ex(input logic [15:0] s, input logic co, input logic ov);
        return {co, ov, s};
    endfunction

    // Reference: plain 17-bit addition, overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] full;
        logic        ov;
        full = {1'b0, x} + {1'b0, y} + {16'd0, c};
        ov   = (x[15] == y[15]) && (full[15] != x[15]);
        return {full[16], ov, full[15:0]};
    endfunction

    // Present one operand set; called at posedge+1, returns at posedge+1 after transfer.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic [17:0] exp, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        X        = x;
        Y        = y;
        cin      = c;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waits++;
            if (waits > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", waits);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0h expected no output", {cout, ovf, S});
            end else begin
                chk("result", 32'({cout, ovf, S}), 32'(sb.pop_front()));
            end
        end
    end

    // Random consumer backpressure, changed only just after the active edge.
    always @(posedge clk) begin
        if (rnd_or) begin
            #1;
            out_ready = 1'($urandom);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dv[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        dv[1] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        dv[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        dv[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        dv[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        dv[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        dv[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
        dv[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X         = '0;
        Y         = '0;
        cin       = 1'b0;
`ifdef PREFIX_ADDER_SUB_EN
        sub       = 1'b0;
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'({cout, ovf, S}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Wrap to zero with carry out; latency of two cycles.
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, ex(16'h0000, 1'b1, 1'b0), w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_cycle1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_cycle2_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors back to back.
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            send(dv[i].x, dv[i].y, dv[i].c, ex(dv[i].s, dv[i].co, dv[i].ov), w);
            wsum += w;
        end
        in_valid = 1'b0;
        chk("directed_b2b_waits", 32'(wsum), 32'd0);
        drain();

        // Backpressure: two held, third refused, then accepted on the first handshake.
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, ex(16'h0303, 1'b0, 1'b0), w0);
        send(16'h7000, 16'h1000, 1'b0, ex(16'h8000, 1'b0, 1'b1), w1);
        chk("stall_first_two_waits", 32'(w0 + w1), 32'd0);
        in_valid = 1'b1;
        X        = 16'h00FF;
        Y        = 16'h0001;
        cin      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_result", 32'({cout, ovf, S}), 32'(ex(16'h0303, 1'b0, 1'b0)));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(16'h00FF, 16'h0001, 1'b1, ex(16'h0101, 1'b0, 1'b0), w);
        in_valid = 1'b0;
        chk("third_accepted_on_handshake", 32'(w), 32'd0);
        drain();

        // Random traffic with random gaps and backpressure.
        rnd_or = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                X        = 16'($urandom);
                Y        = 16'($urandom);
                cin      = 1'($urandom);
                @(posedge clk);
                #1;
            end
            rx = 16'($urandom);
            ry = 16'($urandom);
            rc = 1'($urandom);
            send(rx, ry, rc, model(rx, ry, rc), w);
        end
        in_valid = 1'b0;
        rnd_or   = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Full rate with both sides held high.
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rc = 1'($urandom);
            send(rx, ry, rc, model(rx, ry, rc), w);
            wsum += w;
        end
        in_valid = 1'b0;
        chk("full_rate_waits", 32'(wsum), 32'd0);
        drain();

        // Reset with two results in flight.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, ex(16'h3333, 1'b0, 1'b0), w);
        send(16'h0F0F, 16'h00F1, 1'b0, ex(16'h1000, 1'b0, 1'b0), w);
        in_valid = 1'b0;
        chk("inflight_before_reset", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_result", 32'({cout, ovf, S}), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_after_reset", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 1'b0, ex(16'h0002, 1'b0, 1'b0), w);
        in_valid = 1'b0;
        drain();

`ifdef PREFIX_ADDER_SUB_EN
        // Subtraction; cin driven high to show it is ignored.
        sub = 1'b1;
        send(16'h0005, 16'h0007, 1'b1, ex(16'hFFFE, 1'b0, 1'b0), w);
        send(16'h8000, 16'h0001, 1'b1, ex(16'h7FFF, 1'b1, 1'b1), w);
        sub      = 1'b0;
        in_valid = 1'b0;
        drain();
`endif

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits; legal range 2..64.
REQ-002 SHALL have parameter STAGES, default 2, meaning number of pipeline register stages; legal range 1..ceil(log2(WIDTH))+1.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands X, Y, cin are presented.
REQ-006 SHALL have port in_ready  output  1  block accepts the operands this cycle.
REQ-007 SHALL have port X  input  WIDTH  operand A.
REQ-008 SHALL have port Y  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry in.
REQ-010 SHALL have port out_valid  output  1  S, cout, ovf hold a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port S  output  WIDTH  sum.
REQ-013 SHALL have port cout  output  1  carry out of the MSB.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL compute {cout,S} = X + Y + cin modulo 2^(WIDTH+1) with a parallel-prefix (Kogge-Stone) generate/propagate tree; no ripple chain longer than one prefix level.
REQ-016 SHALL set ovf = carry into MSB XOR carry out of MSB.
REQ-017 SHALL spread STAGES register slices evenly across the ceil(log2(WIDTH)) prefix levels plus the final sum XOR, each slice carrying one valid bit.
REQ-018 SHALL accept a transaction on a cycle where in_valid and in_ready are both 1 (transfer), and present its result with out_valid=1 exactly STAGES cycles later when no stall occurs.
REQ-019 SHALL advance slice k when slice k+1 is empty or advancing; the last slice advances when out_ready=1 or out_valid=0 (bubbles collapse).
REQ-020 SHALL drive in_ready = 1 when slice 0 is empty or advancing; in_ready SHALL NOT depend combinationally on in_valid.
REQ-021 SHALL sustain one transfer per cycle while out_ready=1; with out_ready held 0 it SHALL hold exactly STAGES results, then deassert in_ready.
REQ-022 SHALL hold S, cout, ovf, out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL deliver results in acceptance order; no transfer SHALL be lost or duplicated.
REQ-024 SHALL, on a cycle with a simultaneous output handshake and input transfer while full, complete both without a bubble.
REQ-025 SHALL ignore X, Y, cin when in_valid=0.

Reset
REQ-026 SHALL, while rst_n=0, clear all valid bits immediately (out_valid=0) and drive S=0, cout=0, ovf=0.
REQ-027 SHALL drive in_ready=0 during reset and 1 on the first clk edge after rst_n rises.
REQ-028 SHALL discard all in-flight transactions on reset mid-operation; no result of them SHALL appear afterward.

Configuration
REQ-029 SHALL, when macro PREFIX_ADDER_SUB_EN is defined, add port sub  input  1, sampled with the operands: sub=1 computes X + ~Y + 1 (cin ignored), cout=1 meaning no borrow, ovf per REQ-016.
REQ-030 SHALL, when PREFIX_ADDER_SUB_EN is undefined, have no sub port and perform addition only, per REQ-015.

Verification
REQ-031 SHALL cover: WIDTH=16, STAGES=2, X=0xFFFF, Y=0x0001, cin=0, out_ready=1 -> two cycles later S=0x0000, cout=1, ovf=0.
REQ-032 SHALL cover: X=0x7FFF, Y=0x0001, cin=0 -> S=0x8000, cout=0, ovf=1; X=0x8000, Y=0x8000 -> S=0x0000, cout=1, ovf=1.
REQ-033 SHALL cover: out_ready=0, three back-to-back transfers -> two accepted, in_ready=0 on the third; out_ready=1 -> results emitted in order, third accepted during the first output handshake.
REQ-034 SHALL cover: 1000 random transfers with random in_valid/out_ready against a reference model -> all match, in order, at 1 per cycle when both held 1.
REQ-035 SHALL cover: rst_n pulsed low with 2 results in flight -> out_valid=0 immediately, no stale result after release.
REQ-036 SHALL cover: PREFIX_ADDER_SUB_EN defined, sub=1, X=0x0005, Y=0x0007 -> S=0xFFFE, cout=0, ovf=0.
